// File: rtl/bcd_event_counter_pkg.sv
// Shared constants for the BCD event counter and its decade cells.
`timescale 1ns/1ps
package bcd_event_counter_pkg;
  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int unsigned NDIG_MAX = 8;
endpackage

// File: rtl/bcd_event_counter_digit.sv
// One decimal decade: counts 0..9 on inc, wraps to 0, synchronous clear wins.
`timescale 1ns/1ps
module bcd_digit
  import bcd_event_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             tc
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  // Next digit value: clear, wrap at 9, or step.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + BCD_W'(1);
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_event_counter.sv
// NDIG-digit BCD event counter with sticky overflow and a valid/ready snapshot port.
`timescale 1ns/1ps
module bcd_event_counter
  import bcd_event_counter_pkg::*;
#(
  parameter int unsigned NDIG = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cin,
  input  logic                  clr,
  input  logic                  cap_req,
  input  logic                  cap_ready,
  output logic [BCD_W*NDIG-1:0] bcd,
  output logic                  ovf,
  output logic                  cap_valid,
  output logic [BCD_W*NDIG-1:0] cap_data,
  output logic                  cap_drop
);

  localparam int unsigned W = BCD_W * NDIG;

  logic [NDIG:0]   en;
  logic [NDIG-1:0] tc;
  logic [W-1:0]    cnt;

  logic            ovf_q, ovf_d;
  logic            cap_valid_q, cap_valid_d;
  logic [W-1:0]    cap_data_q, cap_data_d;
  logic            cap_drop_q, cap_drop_d;
  logic            accept_c;

  // en[i] = cin and every digit below i sits at 9; en[NDIG] marks a full-scale wrap.
  assign en[0] = cin;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign en[gi+1] = en[gi] & tc[gi];

    bcd_digit u_digit (
      .clk  (clk),
      .rstn (rstn),
      .inc  (en[gi]),
      .clr  (clr),
      .q    (cnt[gi*BCD_W +: BCD_W]),
      .tc   (tc[gi])
    );
  end

  assign accept_c = cap_req & (~cap_valid_q | cap_ready);

  // Overflow flag and snapshot handshake next-state.
  always_comb begin
    ovf_d       = ovf_q;
    cap_valid_d = cap_valid_q;
    cap_data_d  = cap_data_q;
    cap_drop_d  = 1'b0;

    if (clr) begin
      ovf_d = 1'b0;
    end else if (en[NDIG]) begin
      ovf_d = 1'b1;
    end

    if (accept_c) begin
      cap_data_d  = cnt;
      cap_valid_d = 1'b1;
    end else if (cap_valid_q && cap_ready) begin
      cap_valid_d = 1'b0;
    end

    cap_drop_d = cap_req & cap_valid_q & ~cap_ready;
  end

  // Status and snapshot registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q       <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      cap_drop_q  <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      cap_drop_q  <= cap_drop_d;
    end
  end

  assign bcd       = cnt;
  assign ovf       = ovf_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign cap_drop  = cap_drop_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench for bcd_event_counter: driver pushes model results, monitor compares.
`timescale 1ns/1ps
module tb_bcd_event_counter;

  localparam int unsigned NDIG = 2;
  localparam int unsigned W    = 4 * NDIG;

  typedef struct {
    logic [W-1:0] bcd;
    logic         ovf;
    logic         valid;
    logic [W-1:0] data;
    logic         drop;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cin, clr, cap_req, cap_ready;
  logic [W-1:0] bcd, cap_data;
  logic         ovf, cap_valid, cap_drop;

  int errors = 0;
  int checks = 0;

  exp_t sb_q[$];

  // Reference model state: plain integer count plus snapshot bookkeeping.
  int           m_cnt;
  bit           m_ovf, m_pend, m_drop;
  logic [W-1:0] m_snap;
  int           m_mod;

  bcd_event_counter #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cin       (cin),
    .clr       (clr),
    .cap_req   (cap_req),
    .cap_ready (cap_ready),
    .bcd       (bcd),
    .ovf       (ovf),
    .cap_valid (cap_valid),
    .cap_data  (cap_data),
    .cap_drop  (cap_drop)
  );

  always #2.5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(NDIG); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.bcd   = to_bcd(m_cnt);
    e.ovf   = m_ovf;
    e.valid = m_pend;
    e.data  = m_snap;
    e.drop  = m_drop;
    return e;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_ovf  = 0;
    m_pend = 0;
    m_drop = 0;
    m_snap = '0;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge state.
  task automatic step(input bit c, input bit cl, input bit rq, input bit rd);
    bit acc;
    @(negedge clk);
    cin = c; clr = cl; cap_req = rq; cap_ready = rd;
    acc    = rq && (!m_pend || rd);
    m_drop = rq && m_pend && !rd;
    if (acc) m_snap = to_bcd(m_cnt);
    if (acc) m_pend = 1;
    else if (m_pend && rd) m_pend = 0;
    if (cl) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (c) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == m_mod) begin
        m_cnt = 0;
        m_ovf = 1;
      end
    end
    sb_q.push_back(model_now());
  endtask

  task automatic run_cin(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: after every rising edge, pop one expectation if queued and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_bcd",   32'(bcd),       32'(e.bcd));
        chk("sb_ovf",   32'(ovf),       32'(e.ovf));
        chk("sb_valid", 32'(cap_valid), 32'(e.valid));
        chk("sb_data",  32'(cap_data),  32'(e.data));
        chk("sb_drop",  32'(cap_drop),  32'(e.drop));
      end
    end
  end

  initial begin
    m_mod = 1;
    for (int i = 0; i < int'(NDIG); i++) m_mod = m_mod * 10;
    model_reset();
    rstn = 1'b0; cin = 1'b0; clr = 1'b0; cap_req = 1'b0; cap_ready = 1'b0;

    // Reset held: counting input toggles but everything stays zero.
    #1;
    chk("rst_bcd",   32'(bcd),       32'h0);
    chk("rst_ovf",   32'(ovf),       32'h0);
    chk("rst_valid", 32'(cap_valid), 32'h0);
    @(negedge clk); cin = 1'b1; cap_req = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_bcd",   32'(bcd),       32'h0);
    chk("rst_hold_valid", 32'(cap_valid), 32'h0);
    step(0, 0, 0, 0);
    #2;
    rstn = 1'b1;

    // Carry between digits.
    run_cin(9);   settle(); chk("cnt_09", 32'(bcd), 32'h09);
    run_cin(1);   settle(); chk("cnt_10", 32'(bcd), 32'h10);
    run_cin(27);  settle(); chk("cnt_37", 32'(bcd), 32'h37);
    step(0, 1, 0, 0); settle(); chk("clr_37", 32'(bcd), 32'h00);

    // Full scale and sticky overflow.
    run_cin(99);  settle(); chk("fs_99", 32'(bcd), 32'h99); chk("fs_99_ovf", 32'(ovf), 32'h0);
    run_cin(1);   settle(); chk("fs_00", 32'(bcd), 32'h00); chk("fs_00_ovf", 32'(ovf), 32'h1);
    run_cin(5);   settle(); chk("fs_05", 32'(bcd), 32'h05); chk("fs_05_ovf", 32'(ovf), 32'h1);
    step(0, 1, 0, 0); settle(); chk("fs_clr", 32'(bcd), 32'h00); chk("fs_clr_ovf", 32'(ovf), 32'h0);

    // Clear wins over a same-cycle count.
    run_cin(42);  settle(); chk("pri_42", 32'(bcd), 32'h42);
    step(1, 1, 0, 0); settle(); chk("pri_clr", 32'(bcd), 32'h00);

    // Snapshot, hold, drop, and simultaneous consume plus request.
    run_cin(37);
    step(0, 0, 1, 0); settle();
    chk("cap_valid", 32'(cap_valid), 32'h1); chk("cap_37", 32'(cap_data), 32'h37);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0); settle();
      chk("cap_hold", 32'(cap_data), 32'h37);
    end
    step(0, 0, 1, 0); settle();
    chk("cap_drop", 32'(cap_drop), 32'h1); chk("cap_drop_data", 32'(cap_data), 32'h37);
    step(0, 0, 0, 0); settle(); chk("cap_drop_end", 32'(cap_drop), 32'h0);
    step(0, 0, 1, 1); settle();
    chk("cap_renew", 32'(cap_data), 32'h40); chk("cap_renew_valid", 32'(cap_valid), 32'h1);
    step(0, 0, 0, 1); settle(); chk("cap_consume", 32'(cap_valid), 32'h0);

    // Asynchronous reset in the middle of a cycle with a snapshot pending.
    step(0, 1, 0, 0);
    run_cin(45);
    step(0, 0, 1, 0); settle();
    chk("ar_pre_valid", 32'(cap_valid), 32'h1);
    #0.5;
    rstn = 1'b0;
    #0.5;
    chk("ar_bcd",   32'(bcd),       32'h0);
    chk("ar_ovf",   32'(ovf),       32'h0);
    chk("ar_valid", 32'(cap_valid), 32'h0);
    chk("ar_data",  32'(cap_data),  32'h0);
    model_reset();
    #0.2;
    rstn = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) < 70), ($urandom_range(199) == 0),
           ($urandom_range(99) < 20), ($urandom_range(1) == 1));
    end
    step(0, 0, 0, 0);
    settle();
    settle();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
